// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: next-PC selection, stall-time redirect buffer, ROM-window |
// | target trap and fetch/stall counters for the instruction fetch unit.      |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          ROM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] PC_Now,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] PC_Next,
    output logic        flush_ifid,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        addr_err,
    output logic [31:0] err_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Window bounds carried at 33 bits so the upper limit cannot overflow.
    localparam logic [32:0] c_WIN_LO = {1'b0, RESET_PC};
    localparam logic [32:0] c_WIN_HI = {1'b0, RESET_PC} + 33'(4 * ROM_WORDS);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_pending;
    logic [31:0] r_pend_pc;
    logic        r_addr_err;
    logic [31:0] r_err_pc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    state_t      w_next;
    logic [31:0] w_pc_next;
    logic        w_flush;
    logic        w_fetch_valid;
    logic        w_trap;
    logic [31:0] w_trap_pc;
    logic        w_fetch_inc;
    logic        w_stall_inc;
    logic        w_pend_wr;
    logic        w_pend_clr;
    logic        w_redir_act;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_seq_pc;

    function automatic logic f_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} >= c_WIN_LO) &&
               ({1'b0, addr} < c_WIN_HI);
    endfunction

    assign w_redir_act = jr | jmp | br_taken;
    assign w_redir_tgt = jr ? jr_target : (jmp ? jmp_target : br_target);
    assign w_seq_pc    = PC_Now + 32'd4;

    always_comb begin
        w_next        = r_state;
        w_pc_next     = PC_Now;
        w_flush       = 1'b0;
        w_fetch_valid = 1'b0;
        w_trap        = 1'b0;
        w_trap_pc     = 32'd0;
        w_fetch_inc   = 1'b0;
        w_stall_inc   = 1'b0;
        w_pend_wr     = 1'b0;
        w_pend_clr    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_pc_next = RESET_PC;
                w_next    = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (stall) begin
                    w_stall_inc = 1'b1;
                    w_next      = S_STALL;
                    w_pend_wr   = w_redir_act;
                end else begin
                    w_next = S_RUN;
                    // A buffered redirect outranks one arriving now: ID is wrong-path.
                    if (r_pending) begin
                        if (f_legal(r_pend_pc)) begin
                            w_pc_next     = r_pend_pc;
                            w_flush       = 1'b1;
                            w_fetch_valid = 1'b1;
                            w_fetch_inc   = 1'b1;
                            w_pend_clr    = 1'b1;
                        end else begin
                            w_trap    = 1'b1;
                            w_trap_pc = r_pend_pc;
                        end
                    end else if (w_redir_act) begin
                        if (f_legal(w_redir_tgt)) begin
                            w_pc_next     = w_redir_tgt;
                            w_flush       = 1'b1;
                            w_fetch_valid = 1'b1;
                            w_fetch_inc   = 1'b1;
                        end else begin
                            w_trap    = 1'b1;
                            w_trap_pc = w_redir_tgt;
                        end
                    end else if (f_legal(w_seq_pc)) begin
                        w_pc_next     = w_seq_pc;
                        w_fetch_valid = 1'b1;
                        w_fetch_inc   = 1'b1;
                    end else begin
                        w_trap    = 1'b1;
                        w_trap_pc = w_seq_pc;
                    end
                    if (w_trap) begin
                        w_next = S_ERR;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_BOOT;
            r_pending   <= 1'b0;
            r_pend_pc   <= 32'd0;
            r_addr_err  <= 1'b0;
            r_err_pc    <= 32'd0;
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_pend_wr) begin
                r_pending <= 1'b1;
                r_pend_pc <= w_redir_tgt;
            end else if (w_pend_clr) begin
                r_pending <= 1'b0;
            end
            if (w_trap) begin
                r_addr_err <= 1'b1;
                r_err_pc   <= w_trap_pc;
            end
            if (w_fetch_inc) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign PC_Next          = w_pc_next;
    assign flush_ifid       = w_flush;
    assign fetch_valid      = w_fetch_valid;
    assign redirect_pending = r_pending;
    assign addr_err         = r_addr_err;
    assign err_pc           = r_err_pc;
    assign fetch_cnt        = r_fetch_cnt;
    assign stall_cnt        = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer.        |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

    logic        clk;
    logic        Reset;
    logic [31:0] PC_Now;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] PC_Next;
    logic        flush_ifid;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        addr_err;
    logic [31:0] err_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    fetch_sequencer #(
        .RESET_PC (32'h0000_3000),
        .ROM_WORDS(1024)
    ) u_dut (
        .clk             (clk),
        .Reset           (Reset),
        .PC_Now          (PC_Now),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .jmp             (jmp),
        .jmp_target      (jmp_target),
        .jr              (jr),
        .jr_target       (jr_target),
        .PC_Next         (PC_Next),
        .flush_ifid      (flush_ifid),
        .fetch_valid     (fetch_valid),
        .redirect_pending(redirect_pending),
        .addr_err        (addr_err),
        .err_pc          (err_pc),
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt)
    );

    typedef struct {
        string       name;
        bit          is_reg;
        logic [31:0] pc;
        logic        flush;
        logic        fv;
        logic        pend;
        logic        err;
        logic [31:0] epc;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t q_exp[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go(input logic [31:0] pc, input logic s,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic r, input logic [31:0] rt);
        @(posedge clk);
        #1;
        PC_Now = pc; stall = s;
        br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt;
        jr = r; jr_target = rt;
    endtask

    task automatic idle(input logic [31:0] pc);
        go(pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic exp_out(input string name, input logic [31:0] pc,
                           input logic fl, input logic fv);
        exp_t e;
        e = '{name: name, is_reg: 1'b0, pc: pc, flush: fl, fv: fv,
              pend: 1'b0, err: 1'b0, epc: 32'd0, fcnt: 32'd0, scnt: 32'd0};
        q_exp.push_back(e);
    endtask

    task automatic exp_reg(input string name, input logic pd, input logic er,
                           input logic [31:0] epc, input logic [31:0] fc,
                           input logic [31:0] sc);
        exp_t e;
        e = '{name: name, is_reg: 1'b1, pc: 32'd0, flush: 1'b0, fv: 1'b0,
              pend: pd, err: er, epc: epc, fcnt: fc, scnt: sc};
        q_exp.push_back(e);
    endtask

    // Monitor: everything expected for this cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_total++;
            if (!e.is_reg) begin
                if (PC_Next === e.pc && flush_ifid === e.flush && fetch_valid === e.fv)
                    n_pass++;
                else
                    $display("FAIL %s: got pc=%h flush=%b fv=%b, want pc=%h flush=%b fv=%b",
                             e.name, PC_Next, flush_ifid, fetch_valid, e.pc, e.flush, e.fv);
            end else begin
                if (redirect_pending === e.pend && addr_err === e.err && err_pc === e.epc &&
                    fetch_cnt === e.fcnt && stall_cnt === e.scnt)
                    n_pass++;
                else
                    $display("FAIL %s: got pend=%b err=%b epc=%h fcnt=%0d scnt=%0d, want pend=%b err=%b epc=%h fcnt=%0d scnt=%0d",
                             e.name, redirect_pending, addr_err, err_pc, fetch_cnt, stall_cnt,
                             e.pend, e.err, e.epc, e.fcnt, e.scnt);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        PC_Now = 32'd0; stall = 1'b0;
        br_taken = 1'b0; br_target = 32'd0;
        jmp = 1'b0; jmp_target = 32'd0;
        jr = 1'b0; jr_target = 32'd0;

        idle(32'd0);
        exp_out("reset_out", 32'h3000, 1'b0, 1'b0);
        exp_reg("reset_reg", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

        // Boot and sequential fetch
        idle(32'd0); Reset = 1'b0;
        exp_out("boot", 32'h3000, 1'b0, 1'b0);
        idle(32'h3000); exp_out("seq1", 32'h3004, 1'b0, 1'b1);
        idle(32'h3004); exp_out("seq2", 32'h3008, 1'b0, 1'b1);
        idle(32'h3008); exp_out("seq3", 32'h300C, 1'b0, 1'b1);

        // Branch redirect
        go(32'h3010, 1'b0, 1'b1, 32'h3040, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("branch", 32'h3040, 1'b1, 1'b1);
        exp_reg("seq_cnt", 1'b0, 1'b0, 32'd0, 32'd3, 32'd0);
        idle(32'h3040); exp_out("post_branch", 32'h3044, 1'b0, 1'b1);

        // Jump arriving during a three-cycle stall
        go(32'h3044, 1'b1, 1'b0, 32'd0, 1'b1, 32'h3100, 1'b0, 32'd0);
        exp_out("stall1", 32'h3044, 1'b0, 1'b0);
        exp_reg("stall1_reg", 1'b0, 1'b0, 32'd0, 32'd5, 32'd0);
        go(32'h3044, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("stall2", 32'h3044, 1'b0, 1'b0);
        exp_reg("stall2_reg", 1'b1, 1'b0, 32'd0, 32'd5, 32'd1);
        go(32'h3044, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("stall3", 32'h3044, 1'b0, 1'b0);
        idle(32'h3044);
        exp_out("release", 32'h3100, 1'b1, 1'b1);
        exp_reg("release_reg", 1'b1, 1'b0, 32'd0, 32'd5, 32'd3);
        idle(32'h3100);
        exp_out("post_release", 32'h3104, 1'b0, 1'b1);
        exp_reg("pend_clear", 1'b0, 1'b0, 32'd0, 32'd6, 32'd3);

        // Pending entry beats a fresh redirect on the release cycle
        go(32'h3104, 1'b1, 1'b1, 32'h3200, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("stall_br", 32'h3104, 1'b0, 1'b0);
        go(32'h3104, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3300, 1'b0, 32'd0);
        exp_out("pend_wins", 32'h3200, 1'b1, 1'b1);

        // Priority jr > jmp > br
        go(32'h3200, 1'b0, 1'b1, 32'h3400, 1'b1, 32'h3300, 1'b1, 32'h3200);
        exp_out("prio_jr", 32'h3200, 1'b1, 1'b1);
        exp_reg("prio_reg", 1'b0, 1'b0, 32'd0, 32'd8, 32'd4);
        go(32'h3200, 1'b0, 1'b1, 32'h3400, 1'b1, 32'h3300, 1'b0, 32'd0);
        exp_out("prio_jmp", 32'h3300, 1'b1, 1'b1);
        idle(32'h3300); exp_out("post_prio", 32'h3304, 1'b0, 1'b1);

        // Misaligned branch target traps
        go(32'h3304, 1'b0, 1'b1, 32'h3042, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("trap_mis", 32'h3304, 1'b0, 1'b0);
        exp_reg("pre_trap", 1'b0, 1'b0, 32'd0, 32'd11, 32'd4);
        go(32'h3304, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h3000);
        exp_out("err_hold1", 32'h3304, 1'b0, 1'b0);
        exp_reg("err_mis", 1'b0, 1'b1, 32'h3042, 32'd11, 32'd4);
        go(32'h3304, 1'b0, 1'b1, 32'h3400, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_out("err_hold2", 32'h3304, 1'b0, 1'b0);
        exp_reg("err_frozen", 1'b0, 1'b1, 32'h3042, 32'd11, 32'd4);

        // Out-of-window jr target
        idle(32'd0); Reset = 1'b1;
        exp_reg("reset2_reg", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        idle(32'd0); Reset = 1'b0;
        exp_out("boot2", 32'h3000, 1'b0, 1'b0);
        idle(32'h3000); exp_out("seq_b2", 32'h3004, 1'b0, 1'b1);
        go(32'h3004, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h4000);
        exp_out("trap_oob", 32'h3004, 1'b0, 1'b0);
        idle(32'h3004);
        exp_out("err_hold3", 32'h3004, 1'b0, 1'b0);
        exp_reg("err_oob", 1'b0, 1'b1, 32'h4000, 32'd1, 32'd0);

        // Reset between edges while a redirect is buffered
        idle(32'd0); Reset = 1'b1;
        idle(32'd0); Reset = 1'b0;
        idle(32'h3000);
        go(32'h3004, 1'b1, 1'b0, 32'd0, 1'b1, 32'h3100, 1'b0, 32'd0);
        go(32'h3004, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        exp_reg("pend_set", 1'b1, 1'b0, 32'd0, 32'd1, 32'd1);
        go(32'h3004, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #2; Reset = 1'b1;
        exp_out("midreset_out", 32'h3000, 1'b0, 1'b0);
        exp_reg("midreset_reg", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        idle(32'd0); Reset = 1'b0;
        exp_out("boot3", 32'h3000, 1'b0, 1'b0);
        idle(32'h3000);
        exp_out("restart", 32'h3004, 1'b0, 1'b1);
        exp_reg("restart_reg", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

        // Sequential fetch running off the end of the ROM window
        idle(32'h3FF8); exp_out("seq_last", 32'h3FFC, 1'b0, 1'b1);
        idle(32'h3FFC); exp_out("seq_wrap", 32'h3FFC, 1'b0, 1'b0);
        idle(32'h3FFC);
        exp_reg("wrap_reg", 1'b0, 1'b1, 32'h4000, 32'd2, 32'd0);

        @(posedge clk);
        #1;
        if (q_exp.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        done = 1;
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: bench did not reach its end, want completion");
            $fatal(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Next-PC controller for the instruction fetch unit. Each cycle it picks the address the IFU loads on the next clock edge: sequential, branch, jump, jump-register, or hold on stall. It buffers a redirect that arrives during a stall and flushes the wrong-path instruction in IF/ID. It also checks targets against the instruction ROM window, traps on a bad target, and keeps fetch and stall counters.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address; must match the IFU reset PC.
- ROM_WORDS, 1024, instruction ROM depth in words; the legal window is [RESET_PC, RESET_PC + 4*ROM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_Now  in  32  current IFU PC.
- stall  in  1  hazard unit: hold IF and ID this cycle.
- br_taken  in  1  conditional branch resolved taken in ID.
- br_target  in  32  branch target.
- jmp  in  1  J/JAL in ID.
- jmp_target  in  32  jump target.
- jr  in  1  JR in ID.
- jr_target  in  32  register target.
- PC_Next  out  32  address the IFU loads on the next edge (combinational).
- flush_ifid  out  1  invalidate the IF/ID register this edge (combinational).
- fetch_valid  out  1  the instruction fetched on this edge is on-path.
- redirect_pending  out  1  the one-entry redirect buffer is full.
- addr_err  out  1  sticky bad-target trap.
- err_pc  out  32  offending target, captured on trap.
- fetch_cnt  out  32  count of accepted fetches, wraps.
- stall_cnt  out  32  count of stall cycles, wraps.

## Operation
- FSM states: BOOT, RUN, STALL, ERR. Reset forces BOOT asynchronously.
- **BOOT** (one cycle after Reset deasserts)
  - PC_Next = RESET_PC, fetch_valid = 0.
  - Next state is RUN.
- **Active redirect**
  - Priority: jr > jmp > br_taken.
  - A target is legal when bits [1:0] = 0 and it lies inside the ROM window.
- **RUN, stall = 0**
  - PC_Next priority: pending buffer > active redirect > PC_Now + 4.
  - If a redirect or pending entry is applied: flush_ifid = 1 and the buffer clears.
  - fetch_valid = 1 and fetch_cnt increments.
- **RUN or STALL, stall = 1**
  - PC_Next = PC_Now, flush_ifid = 0, fetch_valid = 0, stall_cnt increments.
  - Next state is STALL.
  - An active redirect writes the buffer; a newer redirect overwrites an older one.
- **STALL, stall = 0**
  - Behaves as RUN, so a pending entry is applied in this cycle.
  - Next state is RUN.
- **Illegal target**
  - Applies to an active redirect, and to a pending entry at the moment it would be applied.
  - Next state is ERR; err_pc captures the target and addr_err goes to 1.
  - PC_Next = PC_Now, no flush, counters do not change.
- **ERR**
  - Absorbing until Reset.
  - PC_Next = PC_Now, fetch_valid = 0, all inputs ignored.
- **Sequential wrap**: when PC_Now + 4 leaves the ROM window, enter ERR with err_pc = PC_Now + 4.
- **Arithmetic**: PC_Next = PC_Now + 4 is 32-bit modulo. Counters are 32-bit and wrap from FFFF_FFFF to 0.

## Timing
- Values under asynchronous Reset:
  - state = BOOT, PC_Next = RESET_PC.
  - flush_ifid = 0, fetch_valid = 0.
  - redirect_pending = 0, addr_err = 0, err_pc = 0.
  - fetch_cnt = 0, stall_cnt = 0.
- If Reset asserts mid-stall with an entry pending, the entry is discarded.
- PC_Next and flush_ifid are combinational from the current inputs and state; no extra latency.
- A redirect applied in cycle t means the IFU fetches the target at edge t.
- Redirect latency: one edge from the ID decision, with one flushed slot (no delay slot).
- A redirect buffered during a stall is applied in the first cycle with stall = 0.
- Simultaneous stall and redirect: stall wins and the redirect is buffered.
- Pending entry plus a new redirect in a non-stall cycle: the pending entry wins and the new redirect is dropped. ID is flushed, so that redirect is wrong-path.
- addr_err, err_pc, redirect_pending and the counters are registered outputs.

## Test plan
- **Reset and sequential fetch**
  - Stimulus: Reset pulse, then 4 cycles with no stall.
  - Required: PC_Next is 3000 in BOOT, then 3004, 3008, 300C; fetch_cnt = 3; flush_ifid = 0 throughout.
- **Branch redirect**
  - Stimulus: PC_Now = 3010, br_taken = 1, br_target = 3040.
  - Required: PC_Next = 3040 and flush_ifid = 1 in the same cycle; the next cycle gives 3044.
- **Redirect during stall**
  - Stimulus: stall = 1 for 3 cycles with jmp = 1, jmp_target = 3100 in the first cycle.
  - Required:
    - PC_Next holds PC_Now and redirect_pending = 1.
    - stall_cnt rises by 3.
    - On the release cycle, PC_Next = 3100 and flush_ifid = 1; pending then clears.
- **Priority**
  - Stimulus: jr = 1 (jr_target 3200), jmp = 1 (3300) and br_taken = 1 (3400) in the same cycle.
  - Required: PC_Next = 3200.
- **Trap**
  - Stimulus: br_target = 3042 (misaligned), then a second test with jr_target = 4000 (outside the ROM window).
  - Required: addr_err = 1 and err_pc equals the bad target; PC_Next stays frozen and counters stay fixed until Reset.
- **Reset mid-stall**
  - Stimulus: pending = 1 while stalled, then assert Reset between clock edges.
  - Required: all outputs take their reset values immediately; after release, fetch restarts at 3000.
